// File: rtl/step_phase_sequencer.sv
// Stepper coil sequencer: turns the 3-bit speed code into timed steps on a
// 4-phase coil pattern (full- or half-step), with direction control,
// a per-step strobe and a wrapping step counter.
//
// state | meaning
// IDLE  | not stepping; coils held on the last pattern (HOLD=1) or off
// RUN   | counting the current step period, stepping on terminal count
module step_phase_sequencer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int STEP_SCALE = 10,
  parameter int CNT_W      = 23,
  parameter bit HOLD       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  speed,
  input  logic        dir,
  input  logic        half_step,
  output logic [3:0]  coil,
  output logic        step_pulse,
  output logic        moving,
  output logic [15:0] step_count
);

  typedef enum logic {IDLE, RUN} state_t;

  // Step periods in clk cycles, resolved at elaboration (no runtime divide)
  localparam logic [CNT_W-1:0] PER2 = CNT_W'(CLK_HZ / (2 * STEP_SCALE));
  localparam logic [CNT_W-1:0] PER3 = CNT_W'(CLK_HZ / (3 * STEP_SCALE));
  localparam logic [CNT_W-1:0] PER4 = CNT_W'(CLK_HZ / (4 * STEP_SCALE));
  localparam logic [CNT_W-1:0] PER5 = CNT_W'(CLK_HZ / (5 * STEP_SCALE));
  localparam logic [CNT_W-1:0] PER6 = CNT_W'(CLK_HZ / (6 * STEP_SCALE));

  function automatic logic [CNT_W-1:0] period_of(input logic [2:0] code);
    case (code)
      3'd2:    period_of = PER2;
      3'd3:    period_of = PER3;
      3'd4:    period_of = PER4;
      3'd5:    period_of = PER5;
      3'd6:    period_of = PER6;
      default: period_of = '0;
    endcase
  endfunction

  // Odd indices are the two-coil patterns used by full-step mode
  function automatic logic [3:0] coil_of(input logic [2:0] p);
    case (p)
      3'd0:    coil_of = 4'b1000;
      3'd1:    coil_of = 4'b1100;
      3'd2:    coil_of = 4'b0100;
      3'd3:    coil_of = 4'b0110;
      3'd4:    coil_of = 4'b0010;
      3'd5:    coil_of = 4'b0011;
      3'd6:    coil_of = 4'b0001;
      default: coil_of = 4'b1001;
    endcase
  endfunction

  state_t           state;
  logic [2:0]       spd_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_q;
  logic [2:0]       ph;
  logic             energized;

  logic             spd_run;
  logic             terminal;
  logic [2:0]       ph_step;
  logic [2:0]       ph_nxt;

  // Register the speed code once; everything downstream uses spd_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) spd_q <= 3'd0;
    else     spd_q <= speed;
  end

  // Run decode, terminal count and next phase index (mod 8 via 3-bit wrap)
  always_comb begin
    spd_run  = (spd_q >= 3'd2) && (spd_q <= 3'd6);
    terminal = (state == RUN) && (cnt == period_q - CNT_W'(1));
    ph_step  = half_step ? 3'd1 : (ph[0] ? 3'd2 : 3'd1);
    ph_nxt   = dir ? (ph + ph_step) : (ph - ph_step);
  end

  // Sequencer FSM; period only reloads at a step boundary so no step is cut short
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      period_q   <= '0;
      ph         <= 3'd0;
      energized  <= 1'b0;
      coil       <= 4'b0000;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (spd_run) begin
            period_q  <= period_of(spd_q);
            energized <= 1'b1;
            state     <= RUN;
            coil      <= coil_of(ph);
          end else begin
            coil <= (HOLD && energized) ? coil_of(ph) : 4'b0000;
          end
        end
        RUN: begin
          if (terminal) begin
            cnt        <= '0;
            step_pulse <= 1'b1;
            ph         <= ph_nxt;
            if (spd_run) begin
              period_q <= period_of(spd_q);
              coil     <= coil_of(ph_nxt);
            end else begin
              state <= IDLE;
              coil  <= HOLD ? coil_of(ph_nxt) : 4'b0000;
            end
          end else begin
            cnt  <= cnt + CNT_W'(1);
            coil <= coil_of(ph);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running step tally, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_count <= 16'h0000;
    else     step_count <= step_count + 16'(terminal);
  end

  assign moving = (state == RUN);

endmodule

// File: tb/tb_step_phase_sequencer.sv
// Bench for step_phase_sequencer: two instances (HOLD=1 / HOLD=0) share
// stimulus; a step-timing reference model is checked every cycle, plus
// directed checks of gaps and coil sequences.
module tb_step_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  speed = 3'd1;
  logic        dir = 1'b1;
  logic        half_step = 1'b1;

  logic [3:0]  coil_h, coil_n;
  logic        pulse_h, pulse_n;
  logic        moving_h, moving_n;
  logic [15:0] cnt_h, cnt_n;

  int vectors = 0;
  int miscompares = 0;

  // reference model state (sim clock 1200 Hz, scale 10)
  int m_spd = 0, m_run = 0, m_left = 0, m_ph = 0, m_energ = 0, m_pulse = 0, m_cnt = 0;

  step_phase_sequencer #(.CLK_HZ(1200), .STEP_SCALE(10), .CNT_W(8), .HOLD(1'b1)) u_hold (
    .clk(clk), .rst(rst), .speed(speed), .dir(dir), .half_step(half_step),
    .coil(coil_h), .step_pulse(pulse_h), .moving(moving_h), .step_count(cnt_h));

  step_phase_sequencer #(.CLK_HZ(1200), .STEP_SCALE(10), .CNT_W(8), .HOLD(1'b0)) u_nohold (
    .clk(clk), .rst(rst), .speed(speed), .dir(dir), .half_step(half_step),
    .coil(coil_n), .step_pulse(pulse_n), .moving(moving_n), .step_count(cnt_n));

  always #5 clk = ~clk;

  function automatic logic [3:0] pattern(input int p);
    logic [3:0] tbl [8];
    tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    return tbl[p];
  endfunction

  function automatic int per(input int code);
    return 1200 / (code * 10);
  endfunction

  function automatic bit is_run(input int code);
    return (code >= 2) && (code <= 6);
  endfunction

  function automatic logic [3:0] exp_coil(input bit hold);
    if (m_run != 0 || (hold && m_energ != 0)) return pattern(m_ph);
    return 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance the model by one rising edge using the inputs currently applied
  task automatic model_step();
    int s_old, stp;
    if (rst) begin
      m_spd = 0; m_run = 0; m_left = 0; m_ph = 0; m_energ = 0; m_pulse = 0; m_cnt = 0;
      return;
    end
    s_old = m_spd;
    m_spd = int'(speed);
    m_pulse = 0;
    if (m_run == 0) begin
      if (is_run(s_old)) begin
        m_run = 1; m_left = per(s_old); m_energ = 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_pulse = 1;
        m_cnt = (m_cnt + 1) % 65536;
        stp = half_step ? 1 : ((m_ph % 2 == 0) ? 1 : 2);
        m_ph = (m_ph + (dir ? stp : 8 - stp)) % 8;
        if (is_run(s_old)) m_left = per(s_old);
        else m_run = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("coil_hold", 16'(coil_h), 16'(exp_coil(1'b1)));
    check("coil_nohold", 16'(coil_n), 16'(exp_coil(1'b0)));
    check("pulse_hold", 16'(pulse_h), 16'(m_pulse));
    check("pulse_nohold", 16'(pulse_n), 16'(m_pulse));
    check("moving_hold", 16'(moving_h), 16'(m_run));
    check("moving_nohold", 16'(moving_n), 16'(m_run));
    check("count_hold", cnt_h, 16'(m_cnt));
    check("count_nohold", cnt_n, 16'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pulse_h && n < max);
    check("pulse_seen", 16'(pulse_h), 16'd1);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    model_step();
    #1;
    check("rst_coil_h", 16'(coil_h), 16'h0);
    check("rst_coil_n", 16'(coil_n), 16'h0);
    check("rst_pulse", 16'(pulse_h), 16'h0);
    check("rst_moving", 16'(moving_h), 16'h0);
    check("rst_count", cnt_h, 16'h0);
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] seq_half [3];
    logic [3:0] seq_full [5];
    seq_half = '{4'b1100, 4'b0100, 4'b0110};
    seq_full = '{4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1001};

    // 1: reset with speed stopped
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("idle_coil", 16'(coil_h), 16'h0);
    check("idle_moving", 16'(moving_h), 16'h0);

    // 2: half-step forward at speed 2
    speed = 3'd2; dir = 1'b1; half_step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(200, n);
      check(i == 0 ? "first_gap" : "gap_60", 16'(n), i == 0 ? 16'd62 : 16'd60);
      check("half_coil", 16'(coil_h), 16'(seq_half[i]));
      check("half_count", cnt_h, 16'(i + 1));
    end
    repeat (17) tick();
    async_reset();

    // 3: full-step reverse from ph=0 at speed 6
    speed = 3'd6; dir = 1'b0; half_step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_pulse(200, n);
      check("full_gap", 16'(n), i == 0 ? 16'd22 : 16'd20);
      check("full_coil", 16'(coil_h), 16'(seq_full[i]));
    end

    // 4: speed changes only take effect at step boundaries
    speed = 3'd2;
    wait_pulse(200, n);
    check("gap_before_slow", 16'(n), 16'd20);
    wait_pulse(200, n);
    check("gap_slow", 16'(n), 16'd60);
    repeat (30) tick();
    speed = 3'd6;
    wait_pulse(200, n);
    check("gap_unchanged", 16'(n + 30), 16'd60);
    wait_pulse(200, n);
    check("gap_fast", 16'(n), 16'd20);

    // 5: stop code seen on the terminal cycle
    repeat (18) tick();
    speed = 3'd1;
    wait_pulse(200, n);
    check("stop_term_gap", 16'(n), 16'd2);
    check("stop_term_moving", 16'(moving_h), 16'd0);
    check("stop_term_coil_n", 16'(coil_n), 16'd0);
    check("stop_term_coil_h", 16'(coil_h), 16'(pattern(m_ph)));
    repeat (10) tick();

    // 5b: stop code mid-period lets the current step complete
    dir = 1'b1; half_step = 1'b1;
    speed = 3'd2;
    wait_pulse(200, n);
    check("restart_gap", 16'(n), 16'd62);
    repeat (10) tick();
    speed = 3'd1;
    wait_pulse(200, n);
    check("stop_mid_gap", 16'(n), 16'd50);
    check("stop_mid_moving", 16'(moving_h), 16'd0);
    repeat (5) tick();

    // 6: step counter wrap
    speed = 3'd6;
    wait_pulse(200, n);
    repeat (5) tick();
    force u_hold.step_count = 16'hFFFF;
    force u_nohold.step_count = 16'hFFFF;
    m_cnt = 65535;
    repeat (2) tick();
    release u_hold.step_count;
    release u_nohold.step_count;
    check("count_forced", cnt_h, 16'hFFFF);
    wait_pulse(200, n);
    check("wrap_gap", 16'(n), 16'd13);
    check("count_wrap", cnt_h, 16'h0000);
    wait_pulse(200, n);
    check("count_after_wrap", cnt_h, 16'h0001);

    // randomized segments against the model
    for (int i = 0; i < 40; i++) begin
      speed = 3'($urandom_range(0, 7));
      dir = 1'($urandom_range(0, 1));
      half_step = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 90)) tick();
    end
    speed = 3'd1;
    repeat (80) tick();
    check("final_moving", 16'(moving_h), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
